// File: rtl/shift_tx_scheduler.sv
// rtl/shift_tx_scheduler.sv - two-requester round-robin scheduler for a shared parallel-load shift register
//
// Purpose: arbitrates between two parallel words, loads the winner into an
// external LSB-first shift register and paces the serial output at DIV
// clocks per bit, then pulses done with the served requester's id.
//
// Ports:
//   CLK      - system clock, rising edge
//   reset    - asynchronous active-high reset
//   req[1:0] - per-requester word-available flags, held until ack
//   data0/1  - requester words, sampled in the ack cycle
//   pause    - freezes bit timing while shifting
//   ack[1:0] - one-cycle accept pulse per requester
//   sr_par   - registered word for the shift register's parallel input
//   sr_load  - shift register parallel-load strobe
//   sr_en    - shift register enable
//   frame    - sout carries a valid data bit
//   busy     - scheduler not idle
//   done     - one-cycle completion pulse
//   done_id  - requester served, valid with done
`timescale 1ns/1ps
module shift_tx_scheduler #(
    parameter int N   = 8,
    parameter int DIV = 4
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic [1:0]   req,
    input  logic [N-1:0] data0,
    input  logic [N-1:0] data1,
    input  logic         pause,
    output logic [1:0]   ack,
    output logic [N-1:0] sr_par,
    output logic         sr_load,
    output logic         sr_en,
    output logic         frame,
    output logic         busy,
    output logic         done,
    output logic         done_id
);

    localparam int BW = $clog2(N);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] N_LAST   = BW'(N - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  sr_par_q, sr_par_d;
    logic          done_id_q, done_id_d;
    logic          last_grant_q, last_grant_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          grant;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            sr_par_q     <= '0;
            done_id_q    <= 1'b0;
            last_grant_q <= 1'b1;
            bit_cnt_q    <= '0;
            div_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            sr_par_q     <= sr_par_d;
            done_id_q    <= done_id_d;
            last_grant_q <= last_grant_d;
            bit_cnt_q    <= bit_cnt_d;
            div_cnt_q    <= div_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sr_par_d     = sr_par_q;
        done_id_d    = done_id_q;
        last_grant_d = last_grant_q;
        bit_cnt_d    = bit_cnt_q;
        div_cnt_d    = div_cnt_q;
        grant        = 1'b0;
        ack          = 2'b00;
        sr_load      = 1'b0;
        sr_en        = 1'b0;
        frame        = 1'b0;
        done         = 1'b0;
        busy         = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                // ack is gated by reset so every output reads 0 while reset is held
                if ((req != 2'b00) && !reset) begin
                    // contested: the requester not served last time wins
                    grant        = (req == 2'b11) ? ~last_grant_q : req[1];
                    ack          = grant ? 2'b10 : 2'b01;
                    sr_par_d     = grant ? data1 : data0;
                    done_id_d    = grant;
                    last_grant_d = grant;
                    state_d      = LOAD;
                end
            end
            LOAD: begin
                sr_load   = 1'b1;
                sr_en     = 1'b1;
                bit_cnt_d = '0;
                div_cnt_d = '0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                frame = 1'b1;
                if (!pause) begin
                    if (div_cnt_q == DIV_LAST) begin
                        div_cnt_d = '0;
                        // last bit is not shifted out; its hold time ends the frame
                        if (bit_cnt_q == N_LAST) begin
                            state_d = DONE;
                        end else begin
                            sr_en     = 1'b1;
                            bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end else begin
                        div_cnt_d = div_cnt_q + DW'(1);
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign sr_par  = sr_par_q;
    assign done_id = done_id_q;

endmodule

// File: tb/tb_shift_tx_scheduler.sv
// tb/tb_shift_tx_scheduler.sv - directed self-checking bench for shift_tx_scheduler
`timescale 1ns/1ps
module tb_shift_tx_scheduler;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req = 2'b00;
    logic [7:0] data0 = 8'h00, data1 = 8'h00;
    logic       pause = 1'b0;
    logic [1:0] ack;
    logic [7:0] sr_par;
    logic       sr_load, sr_en, frame, busy, done, done_id;

    logic [1:0] req5 = 2'b00;
    logic [7:0] data0_5 = 8'h00, data1_5 = 8'h00;
    logic       pause5 = 1'b0;
    logic [1:0] ack5;
    logic [7:0] sr_par5;
    logic       sr_load5, sr_en5, frame5, busy5, done5, done_id5;

    shift_tx_scheduler #(.N(8), .DIV(4)) dut (
        .CLK(CLK), .reset(reset), .req(req), .data0(data0), .data1(data1),
        .pause(pause), .ack(ack), .sr_par(sr_par), .sr_load(sr_load),
        .sr_en(sr_en), .frame(frame), .busy(busy), .done(done), .done_id(done_id)
    );

    shift_tx_scheduler #(.N(8), .DIV(1)) dut_div1 (
        .CLK(CLK), .reset(reset), .req(req5), .data0(data0_5), .data1(data1_5),
        .pause(pause5), .ack(ack5), .sr_par(sr_par5), .sr_load(sr_load5),
        .sr_en(sr_en5), .frame(frame5), .busy(busy5), .done(done5), .done_id(done_id5)
    );

    always #5 CLK = ~CLK;

    // external shift registers: parallel load, shift right, sout = bit 0
    logic [7:0] shreg, shreg5;
    always @(posedge CLK or posedge reset) begin
        if (reset) begin
            shreg  <= 8'h00;
            shreg5 <= 8'h00;
        end else begin
            if (sr_load)      shreg <= sr_par;
            else if (sr_en)   shreg <= shreg >> 1;
            if (sr_load5)     shreg5 <= sr_par5;
            else if (sr_en5)  shreg5 <= shreg5 >> 1;
        end
    end
    wire sout  = shreg[0];
    wire sout5 = shreg5[0];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // results of one observed word, counted from the grant cycle (k=0)
    int         done_off, done_cnt, en_cnt, en_in_pause, load_viol, frame_len, nbits;
    int         bitlen [8];
    logic [7:0] word;
    logic [1:0] ack_done, ack_next;
    logic       busy_next, busy_k1, id_at_done;

    task automatic observe(input int rq_from, input logic [1:0] rq_val,
                           input int ps, input int pl, input logic [7:0] nd0);
        int  k;
        logic prev_shift;
        k = 0; prev_shift = 1'b0;
        done_off = -1; done_cnt = 0; en_cnt = 0; en_in_pause = 0; load_viol = 0;
        frame_len = 0; nbits = 0; word = 8'h00; ack_done = 2'b11; ack_next = 2'b11;
        busy_next = 1'b1; busy_k1 = 1'b0; id_at_done = 1'b0;
        for (int i = 0; i < 8; i++) bitlen[i] = 0;
        while (k < 200 && !(done_off >= 0 && k == done_off + 1)) begin
            k++;
            @(posedge CLK); #1;
            req   = (k >= rq_from) ? rq_val : 2'b00;
            pause = (k >= ps && k < ps + pl);
            if (k == 1) data0 = nd0;
            @(negedge CLK);
            if (k == 1) busy_k1 = busy;
            if (sr_load && !sr_en) load_viol++;
            if (sr_en && !sr_load) en_cnt++;
            if (pause && sr_en) en_in_pause++;
            if (frame) begin
                if ((frame_len == 0 || prev_shift) && nbits < 8) begin
                    word[nbits] = sout;
                    nbits++;
                end
                if (nbits > 0) bitlen[nbits-1]++;
                frame_len++;
            end
            prev_shift = frame && sr_en;
            if (done) begin
                if (done_off < 0) begin
                    done_off   = k;
                    id_at_done = done_id;
                    ack_done   = ack;
                end
                done_cnt++;
            end
            if (done_off >= 0 && k == done_off + 1) begin
                ack_next  = ack;
                busy_next = busy;
            end
        end
        pause = 1'b0;
    endtask

    function automatic int bad_holds(input int skip, input int want);
        int b;
        b = 0;
        for (int i = 0; i < 8; i++)
            if (i != skip && bitlen[i] != want) b++;
        return b;
    endfunction

    initial begin
        // reset state
        req = 2'b00;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_eq("rst_ack", ack, 2'b00);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_outs", {sr_load, sr_en, frame, done, done_id}, 5'b0);
        check_eq("rst_sr_par", sr_par, 8'h00);
        @(posedge CLK); #1 reset = 1'b0;

        // test 1: single request, A5, DIV=4
        @(posedge CLK); #1;
        req = 2'b01; data0 = 8'hA5;
        @(negedge CLK);
        check_eq("t1_ack", ack, 2'b01);
        observe(999, 2'b00, 999, 0, 8'hA5);
        check_eq("t1_busy_load", busy_k1, 1);
        check_eq("t1_word", word, 8'hA5);
        check_eq("t1_holds", bad_holds(-1, 4), 0);
        check_eq("t1_en_pulses", en_cnt, 7);
        check_eq("t1_frame_len", frame_len, 32);
        check_eq("t1_done_off", done_off, 34);
        check_eq("t1_done_id", id_at_done, 0);
        check_eq("t1_done_cnt", done_cnt, 1);
        check_eq("t1_load_en", load_viol, 0);

        // test 2: both request after reset, requester 0 first
        @(posedge CLK); #1 reset = 1'b1;
        @(posedge CLK); #1 reset = 1'b0;
        req = 2'b11; data0 = 8'h0F; data1 = 8'h3C;
        @(negedge CLK);
        check_eq("t2_ack_first", ack, 2'b01);
        observe(1, 2'b10, 999, 0, 8'h0F);
        check_eq("t2a_word", word, 8'h0F);
        check_eq("t2a_done_id", id_at_done, 0);
        check_eq("t2a_no_ack_in_done", ack_done, 2'b00);
        check_eq("t2a_ack1_after_done", ack_next, 2'b10);
        check_eq("t2a_busy_idle", busy_next, 0);
        observe(34, 2'b11, 999, 0, 8'h0F);
        check_eq("t2b_busy_load", busy_k1, 1);
        check_eq("t2b_word", word, 8'h3C);
        check_eq("t2b_done_off", done_off, 34);
        check_eq("t2b_done_id", id_at_done, 1);
        check_eq("t2b_ack_in_done", ack_done, 2'b00);
        check_eq("t2b_rr_ack0", ack_next, 2'b01);

        // test 3 + 6: pause inside bit 3, req0 raised in the DONE cycle
        observe(39, 2'b01, 15, 5, 8'h5A);
        check_eq("t3_word", word, 8'h0F);
        check_eq("t3_bit3_hold", bitlen[3], 9);
        check_eq("t3_other_holds", bad_holds(3, 4), 0);
        check_eq("t3_en_in_pause", en_in_pause, 0);
        check_eq("t3_en_pulses", en_cnt, 7);
        check_eq("t3_done_off", done_off, 39);
        check_eq("t6_no_ack_in_done", ack_done, 2'b00);
        check_eq("t6_ack0_next", ack_next, 2'b01);
        check_eq("t6_busy_idle", busy_next, 0);
        observe(999, 2'b00, 999, 0, 8'h5A);
        check_eq("t6_busy_load", busy_k1, 1);
        check_eq("t6_word", word, 8'h5A);
        check_eq("t6_done_id", id_at_done, 0);

        // test 4: reset during bit 5
        @(posedge CLK); #1;
        req = 2'b01; data0 = 8'hA5;
        @(negedge CLK);
        check_eq("t4_ack", ack, 2'b01);
        done_cnt = 0;
        for (int k = 1; k <= 23; k++) begin
            @(posedge CLK); #1 req = 2'b00;
            @(negedge CLK);
            if (done) done_cnt++;
        end
        check_eq("t4_in_shift", frame, 1);
        @(posedge CLK); #1;
        reset = 1'b1; req = 2'b10;
        #1;
        check_eq("t4_rst_ack", ack, 2'b00);
        check_eq("t4_rst_outs", {sr_load, sr_en, frame, busy, done, done_id}, 6'b0);
        check_eq("t4_rst_sr_par", sr_par, 8'h00);
        check_eq("t4_rst_sout", shreg, 8'h00);
        check_eq("t4_no_done", done_cnt, 0);
        @(posedge CLK); #1 reset = 1'b0;
        @(negedge CLK);
        check_eq("t4_ack1_after_rst", ack, 2'b10);
        check_eq("t4_busy_idle", busy, 0);
        observe(999, 2'b00, 999, 0, 8'hA5);
        check_eq("t4_word", word, 8'h3C);
        check_eq("t4_done_id", id_at_done, 1);

        // test 5: DIV=1 instance
        @(posedge CLK); #1;
        req5 = 2'b10; data1_5 = 8'h81;
        @(negedge CLK);
        check_eq("t5_ack", ack5, 2'b10);
        begin
            int flen, doff, nb;
            logic [7:0] w;
            logic did;
            flen = 0; doff = -1; nb = 0; w = 8'h00; did = 1'b0;
            for (int k = 1; k <= 14; k++) begin
                @(posedge CLK); #1 req5 = 2'b00;
                @(negedge CLK);
                if (frame5) begin
                    if (nb < 8) w[nb] = sout5;
                    nb++;
                    flen++;
                end
                if (done5 && doff < 0) begin
                    doff = k;
                    did  = done_id5;
                end
            end
            check_eq("t5_frame_len", flen, 8);
            check_eq("t5_word", w, 8'h81);
            check_eq("t5_done_off", doff, 10);
            check_eq("t5_done_id", did, 1);
            check_eq("t5_idle", busy5, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_tx_scheduler.md
Name: shift_tx_scheduler

Overview:
Sequences an external N-bit parallel-load/serial-out shift register so it can be shared by two requesters. It arbitrates round-robin between two parallel words and drives the register's load/enable/parallel-data inputs. It holds each bit on the serial output for DIV clock cycles and reports completion with the winning requester's id. It sits between producer logic and the shift register; the shift register's reset is tied to the same reset net.

Parameters:
N, 8, word width; must match the shift register; N >= 2
DIV, 4, clock cycles each bit is held on the shift register's serial output; DIV >= 1

Ports:
CLK  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req  input  2  req[i] high = requester i has a word; held until ack[i]
data0  input  N  word from requester 0; sampled in the ack[0] cycle
data1  input  N  word from requester 1; sampled in the ack[1] cycle
pause  input  1  freezes bit timing while in SHIFT
ack  output  2  one-cycle pulse; word of requester i accepted
sr_par  output  N  registered word driving the shift register's parallel input
sr_load  output  1  shift register parallel-load strobe
sr_en  output  1  shift register enable
frame  output  1  high while sout carries a valid data bit
busy  output  1  high whenever state is not IDLE
done  output  1  one-cycle completion pulse
done_id  output  1  requester served; registered at grant, valid with done

Behaviour:
- Reset, asynchronous: state=IDLE, sr_par=0, done_id=0, bit_cnt=0, div_cnt=0, last_grant=1 (requester 0 wins first contest). All outputs are 0 during and after reset.
- States: IDLE, LOAD, SHIFT, DONE. Outputs are decoded combinationally from registered state and counters; ack also depends on req.
- IDLE, arbitration:
  - Only one req bit high: grant that requester.
  - Both high: grant the requester != last_grant.
  - In the grant cycle: ack[g]=1, sr_par<=data_g, done_id<=g, last_grant<=g, next state LOAD.
  - No req: stay in IDLE.
  - ack is never asserted outside IDLE.
- LOAD, 1 cycle: sr_load=1, sr_en=1. Next state SHIFT with bit_cnt=0, div_cnt=0. Bit 0 of the word appears on sout from the next cycle.
- SHIFT: frame=1.
  - If pause=1: div_cnt holds, sr_en=0.
  - Else div_cnt increments.
  - At div_cnt==DIV-1 with bit_cnt<N-1: sr_en=1 for one cycle (shift), bit_cnt++, div_cnt<=0.
  - At div_cnt==DIV-1 with bit_cnt==N-1: no shift, next state DONE.
  - sr_load=0 throughout SHIFT.
- DONE, 1 cycle: done=1, frame=0. Next state IDLE; a new grant is possible in the following cycle.
- Timing with grant at cycle T and no pause: LOAD at T+1; frame high T+2 .. T+1+N*DIV; done at T+2+N*DIV; earliest next ack at T+3+N*DIV.
- Invariants:
  - sr_load implies sr_en.
  - sr_par is stable from grant until the next grant.
  - Exactly N-1 shift pulses per word.
- A request dropped before ack is ignored; there is no partial state.
- Reset mid-word: immediate return to IDLE and the shift register clears. No done is issued and the word is lost. last_grant returns to 1.
- bit_cnt width = clog2(N); div_cnt width = max(1, clog2(DIV)).
- DIV=1: one shift per cycle; frame lasts exactly N cycles.

Test Plan:
1. N=8, DIV=4. req=01, data0=8'hA5 after reset; ack[0] at T. Required: sout = 1,0,1,0,0,1,0,1, each held 4 cycles, from T+2. Exactly 7 sr_en pulses after LOAD. done=1 and done_id=0 at T+34.
2. Both req high after reset, data0=8'h0F, data1=8'h3C. Required: requester 0 served first. Then ack[1] at done+1, sout = 0,0,1,1,1,1,0,0. Re-assert both requests: requester 0 wins again.
3. pause=1 for 5 cycles in the middle of bit 3. Required: bit 3 held 4+5=9 cycles, no sr_en during the pause, done delayed by exactly 5 cycles.
4. reset asserted during bit 5. Required: all outputs 0 in the same cycle, no done pulse. Afterwards a single req1 is acked in the first IDLE cycle after reset release.
5. DIV=1, N=8, data1=8'h81. Required: frame high exactly 8 cycles, sout = 1,0,0,0,0,0,0,1, done 10 cycles after ack.
6. req0 asserted in the DONE cycle. Required: no ack in DONE; ack[0] in the next cycle; busy low for exactly that one IDLE cycle.
